// File: rtl/alu_iface_pkg.sv
// Shared definitions for the ALU byte-stream front-end: FSM state encoding and ALU opcodes.
// The opcodes are also used by the ALU itself and by its bench.
package alu_iface_pkg;

  localparam logic [2:0] ST_IDLE_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;

  typedef enum logic [2:0] {
    IDLE_A  = ST_IDLE_A,
    WAIT_B  = ST_WAIT_B,
    WAIT_OP = ST_WAIT_OP,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_iface_timer.sv
// Inter-byte timeout counter for alu_uart_iface. Only compiled when ALU_IFACE_TIMEOUT_EN is defined,
// so the default build carries no counter logic at all.
`ifdef ALU_IFACE_TIMEOUT_EN
module alu_iface_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic srst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (srst || !run || clear) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Fires in the last idle cycle so the FSM is back in IDLE_A after exactly TIMEOUT_CYCLES cycles.
  assign expired = run && (count_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/alu_uart_iface.sv
// UART byte-stream front-end for the ALU: collects A, B, opcode; transmits the sign-extended result.
// Optional inter-byte timeout enabled by defining ALU_IFACE_TIMEOUT_EN.
module alu_uart_iface
  import alu_iface_pkg::*;
#(
  parameter int NB_DATA  = 8,
  parameter int SIZE_OP  = 8,
  parameter int SIZE_COD = 6
`ifdef ALU_IFACE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic [NB_DATA-1:0]  i_rx_data,
  input  logic                i_rx_done,
  input  logic [SIZE_OP-1:0]  i_alu_result,
  output logic [SIZE_OP-1:0]  o_dato_a,
  output logic [SIZE_OP-1:0]  o_dato_b,
  output logic [SIZE_COD-1:0] o_op_code,
  output logic [NB_DATA-1:0]  o_tx_data,
  output logic                o_tx_start,
  input  logic                i_tx_done,
  output logic                o_busy
);

  state_t state_reg, state_next;

  logic [SIZE_OP-1:0]  dato_a_reg;
  logic [SIZE_OP-1:0]  dato_b_reg;
  logic [SIZE_COD-1:0] op_code_reg;
  logic [NB_DATA-1:0]  tx_data_reg;
  logic                tx_start_reg;
  logic [NB_DATA-1:0]  result_ext;
  logic                timeout_expired;

  assign result_ext = NB_DATA'($signed(i_alu_result));

`ifdef ALU_IFACE_TIMEOUT_EN
  alu_iface_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .srst   (i_reset),
    .run    ((state_reg == WAIT_B) || (state_reg == WAIT_OP)),
    .clear  (i_rx_done),
    .expired(timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_reg <= IDLE_A;
    end else begin
      state_reg <= state_next;
    end
  end

  // A received byte always takes priority over a simultaneous timeout expiry.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE_A:  if (i_rx_done) state_next = WAIT_B;
      WAIT_B: begin
        if (i_rx_done)            state_next = WAIT_OP;
        else if (timeout_expired) state_next = IDLE_A;
      end
      WAIT_OP: begin
        if (i_rx_done)            state_next = SEND;
        else if (timeout_expired) state_next = IDLE_A;
      end
      SEND:    state_next = WAIT_TX;
      WAIT_TX: if (i_tx_done) state_next = IDLE_A;
      default: state_next = IDLE_A;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      dato_a_reg   <= '0;
      dato_b_reg   <= '0;
      op_code_reg  <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
    end else begin
      tx_start_reg <= (state_reg == SEND);
      if (state_reg == IDLE_A && i_rx_done)  dato_a_reg  <= i_rx_data[SIZE_OP-1:0];
      if (state_reg == WAIT_B && i_rx_done)  dato_b_reg  <= i_rx_data[SIZE_OP-1:0];
      if (state_reg == WAIT_OP && i_rx_done) op_code_reg <= i_rx_data[SIZE_COD-1:0];
      if (state_reg == SEND)                 tx_data_reg <= result_ext;
    end
  end

  assign o_dato_a   = dato_a_reg;
  assign o_dato_b   = dato_b_reg;
  assign o_op_code  = op_code_reg;
  assign o_tx_data  = tx_data_reg;
  assign o_tx_start = tx_start_reg;
  assign o_busy     = (state_reg == SEND) || (state_reg == WAIT_TX);

endmodule

// File: tb/tb_alu_uart_iface.sv
// Self-checking bench for alu_uart_iface: directed frames plus randomized frames against an
// arithmetic reference model; a behavioural ALU is attached to the DUT operand outputs.
module tb_alu_uart_iface;
  import alu_iface_pkg::*;

  localparam int NB_DATA  = 8;
  localparam int SIZE_OP  = 8;
  localparam int SIZE_COD = 6;

  logic                clock = 1'b0;
  logic                i_reset;
  logic [NB_DATA-1:0]  i_rx_data;
  logic                i_rx_done;
  logic [SIZE_OP-1:0]  i_alu_result;
  logic [SIZE_OP-1:0]  o_dato_a;
  logic [SIZE_OP-1:0]  o_dato_b;
  logic [SIZE_COD-1:0] o_op_code;
  logic [NB_DATA-1:0]  o_tx_data;
  logic                o_tx_start;
  logic                i_tx_done;
  logic                o_busy;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  alu_uart_iface #(
    .NB_DATA (NB_DATA),
    .SIZE_OP (SIZE_OP),
    .SIZE_COD(SIZE_COD)
`ifdef ALU_IFACE_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .i_alu_result(i_alu_result),
    .o_dato_a    (o_dato_a),
    .o_dato_b    (o_dato_b),
    .o_op_code   (o_op_code),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .o_busy      (o_busy)
  );

  // Behavioural ALU attached to the DUT operands (the environment, not the reference).
  always_comb begin
    case (o_op_code)
      OP_ADD:  i_alu_result = o_dato_a + o_dato_b;
      OP_SUB:  i_alu_result = o_dato_a - o_dato_b;
      OP_AND:  i_alu_result = o_dato_a & o_dato_b;
      OP_OR:   i_alu_result = o_dato_a | o_dato_b;
      OP_XOR:  i_alu_result = o_dato_a ^ o_dato_b;
      OP_NOR:  i_alu_result = ~(o_dato_a | o_dato_b);
      OP_SRA:  i_alu_result = $signed(o_dato_a) >>> o_dato_b;
      OP_SRL:  i_alu_result = o_dato_a >> o_dato_b;
      default: i_alu_result = '0;
    endcase
  end

  // Reference: integer arithmetic on the sent bytes, truncated to SIZE_OP, sign-extended to a byte.
  function automatic int ref_result(input int a_byte, input int b_byte, input int op_byte);
    int mask;
    int a;
    int b;
    int a_s;
    int r;
    mask = (1 << SIZE_OP) - 1;
    a    = a_byte & mask;
    b    = b_byte & mask;
    a_s  = (a >= (1 << (SIZE_OP - 1))) ? a - (1 << SIZE_OP) : a;
    case (op_byte & 63)
      32:      r = a + b;
      34:      r = a - b;
      36:      r = a & b;
      37:      r = a | b;
      38:      r = a ^ b;
      39:      r = ~(a | b);
      3:       r = (b >= 31) ? ((a_s < 0) ? -1 : 0) : (a_s >>> b);
      2:       r = (b >= 31) ? 0 : (a >> b);
      default: r = 0;
    endcase
    r = r & mask;
    if (r >= (1 << (SIZE_OP - 1))) r = r + 256 - (1 << SIZE_OP);
    return r & 255;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, " dato_a"}, o_dato_a, 0);
    check_val({tag, " dato_b"}, o_dato_b, 0);
    check_val({tag, " op_code"}, o_op_code, 0);
    check_val({tag, " tx_data"}, o_tx_data, 0);
    check_val({tag, " tx_start"}, o_tx_start, 0);
    check_val({tag, " busy"}, o_busy, 0);
  endtask

  // stray_mode: 0 none, 1 extra byte in WAIT_TX, 2 extra byte coinciding with i_tx_done.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int gap, input int stray_mode, input string tag);
    logic [7:0] exp_tx;
    exp_tx = 8'(ref_result(int'(a), int'(b), int'(op)));
    send_byte(a);
    idle(gap);
    send_byte(b);
    idle(gap);
    send_byte(op);
    check_val({tag, " start_early"}, o_tx_start, 0);
    check_val({tag, " busy_send"}, o_busy, 1);
    tick();
    check_val({tag, " start"}, o_tx_start, 1);
    check_val({tag, " tx_data"}, o_tx_data, exp_tx);
    tick();
    check_val({tag, " start_once"}, o_tx_start, 0);
    check_val({tag, " busy_wait"}, o_busy, 1);
    if (stray_mode == 1) send_byte(8'h55);
    idle($urandom_range(0, 3));
    i_tx_done = 1'b1;
    if (stray_mode == 2) begin
      i_rx_data = 8'hAA;
      i_rx_done = 1'b1;
    end
    tick();
    i_tx_done = 1'b0;
    i_rx_done = 1'b0;
    check_val({tag, " busy_done"}, o_busy, 0);
    check_val({tag, " hold_a"}, o_dato_a, a);
    check_val({tag, " hold_b"}, o_dato_b, b);
    check_val({tag, " hold_op"}, o_op_code, op[5:0]);
    check_val({tag, " hold_tx"}, o_tx_data, exp_tx);
    $display("frame %s: a=%02h b=%02h op=%02h gap=%0d stray=%0d tx=%02h exp=%02h",
             tag, a, b, op, gap, stray_mode, o_tx_data, exp_tx);
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [7:0] op;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    i_reset   = 1'b1;
    i_rx_data = '0;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    idle(3);
    check_zero("reset");
    i_reset = 1'b0;
    tick();

    run_frame(8'h05, 8'h03, 8'h20, 1, 0, "add");
    run_frame(8'h80, 8'h02, 8'h03, 0, 0, "sra");
    run_frame(8'h80, 8'h02, 8'h02, 2, 0, "srl");
    run_frame(8'h05, 8'h03, 8'h20, 0, 1, "add_stray");
    run_frame(8'h01, 8'h01, 8'h24, 0, 0, "and");
    run_frame(8'h0F, 8'h01, 8'h3F, 0, 2, "illegal");

`ifdef ALU_IFACE_TIMEOUT_EN
    send_byte(8'h07);
    idle(20);
    check_val("timeout busy", o_busy, 0);
    check_val("timeout keep_a", o_dato_a, 8'h07);
    run_frame(8'h01, 8'h02, 8'h25, 0, 0, "or_after_timeout");
`endif

    // Reset one cycle after the second byte aborts the frame.
    send_byte(8'h11);
    send_byte(8'h22);
    idle(1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_zero("rst_mid");
    for (int i = 0; i < 5; i++) begin
      check_val("rst_mid no_start", o_tx_start, 0);
      tick();
    end
    run_frame(8'h09, 8'h04, 8'h22, 1, 0, "sub_after_rst");

    // Reset while waiting for the transmitter; a late i_tx_done must be ignored.
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h26);
    tick();
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_zero("rst_wait_tx");
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("rst_wait_tx no_start", o_tx_start, 0);
      check_val("rst_wait_tx busy", o_busy, 0);
      tick();
    end
    run_frame(8'h33, 8'h44, 8'h26, 0, 0, "xor_after_rst");

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 7) == 0) op = 8'($urandom_range(0, 255));
      else op = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
      run_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), op,
                $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
